// File: rtl/truth_table_scorer.sv
// Hardware fitness scorer: sweeps every input vector through an external candidate,
// holds each one for SETTLE cycles, then counts candidate output bits that match the stored target table.
module truth_table_scorer #(
  parameter  int N_IN    = 4,
  parameter  int N_OUT   = 4,
  parameter  int SETTLE  = 2,
  localparam int SCORE_W = N_IN + $clog2(N_OUT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               target_we,
  input  logic [N_IN-1:0]    target_addr,
  input  logic [N_OUT-1:0]   target_data,
  output logic [N_IN-1:0]    dut_in,
  input  logic [N_OUT-1:0]   dut_out,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] score,
  output logic               perfect,
  output logic [1:0]         dbg_state
);

  localparam int DEPTH = 1 << N_IN;
  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(DEPTH * N_OUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [N_IN-1:0]    r_vec;
  logic [CNT_W-1:0]   r_cnt;
  logic [SCORE_W-1:0] r_acc;
  logic [SCORE_W-1:0] r_score;
  logic               r_perfect;
  logic [N_OUT-1:0]   r_table [DEPTH];

  logic [N_OUT-1:0]   w_match;
  logic [SCORE_W-1:0] w_hits;
  logic [SCORE_W-1:0] w_acc_next;
  logic               w_last;
  logic               w_settled;

  assign w_match    = ~(dut_out ^ r_table[r_vec]);
  assign w_acc_next = r_acc + w_hits;
  assign w_last     = (r_vec == '1);
  assign w_settled  = (r_cnt == CNT_W'(SETTLE - 1));

  always_comb begin
    w_hits = '0;
    for (int i = 0; i < N_OUT; i++) begin
      w_hits = w_hits + SCORE_W'(w_match[i]);
    end
  end

  // Target table has no reset so a programmed target survives a sweep abort.
  always_ff @(posedge clk) begin
    if (target_we && r_state == S_IDLE) begin
      r_table[target_addr] <= target_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_next = S_APPLY;
      S_APPLY:  if (w_settled) w_state_next = S_SAMPLE;
      S_SAMPLE: w_state_next = w_last ? S_DONE : S_APPLY;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    dbg_state = r_state;
  end

  // Score is committed on the final sample edge so it is valid in the DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vec     <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_score   <= '0;
      r_perfect <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_vec <= '0;
            r_cnt <= '0;
            r_acc <= '0;
          end
        end
        S_APPLY: begin
          r_cnt <= r_cnt + 1'b1;
        end
        S_SAMPLE: begin
          r_acc <= w_acc_next;
          r_cnt <= '0;
          if (w_last) begin
            r_score   <= w_acc_next;
            r_perfect <= (w_acc_next == MAX_SCORE);
          end else begin
            r_vec <= r_vec + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dut_in  = r_vec;
  assign score   = r_score;
  assign perfect = r_perfect;

endmodule

// File: tb/tb_truth_table_scorer.sv
// Directed bench for truth_table_scorer: a 4-in/4-out instance with selectable candidate
// behaviour, plus a 2-in/1-out instance scoring an AND candidate against an XOR target.
module tb_truth_table_scorer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  // Instance A: N_IN=4, N_OUT=4, SETTLE=2.
  logic       start_a = 1'b0;
  logic       target_we_a = 1'b0;
  logic [3:0] target_addr_a = '0;
  logic [3:0] target_data_a = '0;
  logic [3:0] dut_in_a;
  logic [3:0] dut_out_a;
  logic       busy_a, done_a, perfect_a;
  logic [6:0] score_a;
  logic [1:0] dbg_state_a;
  int         mode_a = 0;

  // Instance B: N_IN=2, N_OUT=1, SETTLE=1.
  logic       start_b = 1'b0;
  logic       target_we_b = 1'b0;
  logic [1:0] target_addr_b = '0;
  logic [0:0] target_data_b = '0;
  logic [1:0] dut_in_b;
  logic [0:0] dut_out_b;
  logic       busy_b, done_b, perfect_b;
  logic [2:0] score_b;
  logic [1:0] dbg_state_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Candidate models: 0 = loopback, 1 = inverted, 2 = flip bit 0.
  assign dut_out_a = (mode_a == 0) ? dut_in_a :
                     (mode_a == 1) ? ~dut_in_a : (dut_in_a ^ 4'b0001);
  assign dut_out_b = dut_in_b[0] & dut_in_b[1];

  truth_table_scorer #(.N_IN(4), .N_OUT(4), .SETTLE(2)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .target_we(target_we_a), .target_addr(target_addr_a), .target_data(target_data_a),
    .dut_in(dut_in_a), .dut_out(dut_out_a),
    .busy(busy_a), .done(done_a), .score(score_a), .perfect(perfect_a),
    .dbg_state(dbg_state_a)
  );

  truth_table_scorer #(.N_IN(2), .N_OUT(1), .SETTLE(1)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .target_we(target_we_b), .target_addr(target_addr_b), .target_data(target_data_b),
    .dut_in(dut_in_b), .dut_out(dut_out_b),
    .busy(busy_b), .done(done_b), .score(score_b), .perfect(perfect_b),
    .dbg_state(dbg_state_b)
  );

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic write_a(input int addr, input int data);
    target_we_a   = 1'b1;
    target_addr_a = addr[3:0];
    target_data_a = data[3:0];
    @(negedge clk);
    target_we_a   = 1'b0;
  endtask

  // Start a sweep on A; done must appear in cycle s+49 where s is the start cycle.
  task automatic run_a(input string tag, input int exp_score, input int exp_perfect,
                       input int prev_score, input bit disturb);
    int s;
    bit seen;
    s = cyc;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check_eq({tag, "_busy"}, busy_a, 1);
    check_eq({tag, "_score_kept"}, score_a, prev_score);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (disturb && cyc == s + 5) begin
        start_a = 1'b1;
        target_we_a = 1'b1;
        target_addr_a = 4'h0;
        target_data_a = 4'hF;
      end
      @(negedge clk);
      start_a = 1'b0;
      target_we_a = 1'b0;
      if (done_a) seen = 1'b1;
      else if (cyc == s + 48) check_eq({tag, "_score_pre_done"}, score_a, prev_score);
    end
    check_eq({tag, "_done_seen"}, seen, 1);
    check_eq({tag, "_latency"}, cyc - s, 49);
    check_eq({tag, "_score"}, score_a, exp_score);
    check_eq({tag, "_perfect"}, perfect_a, exp_perfect);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, done_a, 0);
    check_eq({tag, "_idle"}, busy_a, 0);
  endtask

  initial begin
    int s;
    int n_done;
    bit seen;

    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_done", done_a, 0);
    check_eq("rst_score", score_a, 0);
    check_eq("rst_perfect", perfect_a, 0);
    check_eq("rst_dut_in", dut_in_a, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 16; v++) write_a(v, v);
    for (int v = 0; v < 4; v++) begin
      target_we_b   = 1'b1;
      target_addr_b = 2'(v);
      target_data_b = 1'((v == 1) || (v == 2));
      @(negedge clk);
    end
    target_we_b = 1'b0;

    mode_a = 0; run_a("loop", 64, 1, 0, 1'b0);
    mode_a = 1; run_a("inv", 0, 0, 64, 1'b0);
    mode_a = 2; run_a("flip0", 48, 0, 0, 1'b0);
    mode_a = 0; run_a("loop2", 64, 1, 48, 1'b0);

    // Abort a sweep part way through with a one-cycle reset.
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (dut_in_a == 4'd7) seen = 1'b1;
    end
    check_eq("abort_reach_vec7", seen, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort_busy", busy_a, 0);
    check_eq("abort_dut_in", dut_in_a, 0);
    check_eq("abort_score", score_a, 0);
    check_eq("abort_perfect", perfect_a, 0);
    n_done = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done_a) n_done++;
    end
    check_eq("abort_no_done", n_done, 0);
    run_a("after_abort", 64, 1, 0, 1'b0);

    // start and target_we while busy must both be ignored.
    run_a("disturb", 64, 1, 64, 1'b1);
    run_a("table_kept", 64, 1, 64, 1'b0);

    // Instance B: done in cycle s+9, one matching bit (vector 0).
    s = cyc;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check_eq("b_busy", busy_b, 1);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (done_b) seen = 1'b1;
    end
    check_eq("b_done_seen", seen, 1);
    check_eq("b_latency", cyc - s, 9);
    check_eq("b_score", score_b, 1);
    check_eq("b_perfect", perfect_b, 0);
    @(negedge clk);
    check_eq("b_idle", busy_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
